// File: rtl/rc4_decrypt_fsm_if.sv
// Bus bundle for the RC4 decrypt stage.
// Carries the start/busy/done/key_valid handshake with the key-search
// controller, the S RAM port, the encrypted-message ROM port and the
// decrypted-message RAM write port.
//   master : the decrypt FSM (drives addresses, write strobes, status)
//   slave  : memories / controller (drive read data and start)
interface rc4_decrypt_fsm_if #(
    parameter int MSG_AW = 5
);
    logic              start;
    logic              busy;
    logic              done;
    logic              key_valid;
    logic [7:0]        s_q;
    logic [7:0]        s_addr;
    logic [7:0]        s_wdata;
    logic              s_wren;
    logic [7:0]        rom_q;
    logic [MSG_AW-1:0] rom_addr;
    logic [MSG_AW-1:0] dec_addr;
    logic [7:0]        dec_wdata;
    logic              dec_wren;

    modport master (
        input  start, s_q, rom_q,
        output busy, done, key_valid,
        output s_addr, s_wdata, s_wren, rom_addr,
        output dec_addr, dec_wdata, dec_wren
    );

    modport slave (
        output start, s_q, rom_q,
        input  busy, done, key_valid,
        input  s_addr, s_wdata, s_wren, rom_addr,
        input  dec_addr, dec_wdata, dec_wren
    );
endinterface

// File: rtl/rc4_decrypt_fsm.sv
// RC4 pseudo-random generation + XOR decrypt stage.
// Runs PRGA over the shuffled S RAM, XORs each keystream byte with the
// encrypted ROM byte, writes plaintext to the decrypted RAM and reports
// whether every written byte is lowercase ASCII or space.
// Ports:
//   clk   : system clock
//   reset : asynchronous, active-low reset
//   bus   : rc4_decrypt_fsm_if.master (start/busy/done/key_valid,
//           S RAM, message ROM, decrypted RAM)
// All memory reads have one WAIT state; every output is registered.
module rc4_decrypt_fsm #(
    parameter int MSG_LEN     = 32,
    parameter int MSG_AW      = 5,
    parameter bit EARLY_ABORT = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    rc4_decrypt_fsm_if.master bus
);
    localparam logic [MSG_AW-1:0] K_LAST = MSG_AW'(MSG_LEN - 1);

    typedef enum logic [3:0] {
        IDLE, INC_I, WAIT_SI, READ_SI, ADDR_SJ, WAIT_SJ, READ_SJ,
        WRITE_J, WRITE_I, ADDR_F, WAIT_F, READ_F, WRITE_DEC, NEXT, DONE
    } state_t;

    state_t            state, state_n;
    logic [7:0]        i, i_n, j, j_n, si, si_n, sj, sj_n, f, f_n, enc, enc_n;
    logic [MSG_AW-1:0] k, k_n;
    logic [7:0]        s_addr_r, s_addr_n, s_wdata_r, s_wdata_n;
    logic              s_wren_r, s_wren_n;
    logic [MSG_AW-1:0] rom_addr_r, rom_addr_n, dec_addr_r, dec_addr_n;
    logic [7:0]        dec_wdata_r, dec_wdata_n;
    logic              dec_wren_r, dec_wren_n;
    logic              busy_r, busy_n, done_r, done_n, kv_r, kv_n;

    function automatic logic is_text(input logic [7:0] b);
        return (b >= 8'h61 && b <= 8'h7A) || b == 8'h20;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            i           <= '0;
            j           <= '0;
            k           <= '0;
            si          <= '0;
            sj          <= '0;
            f           <= '0;
            enc         <= '0;
            s_addr_r    <= '0;
            s_wdata_r   <= '0;
            s_wren_r    <= 1'b0;
            rom_addr_r  <= '0;
            dec_addr_r  <= '0;
            dec_wdata_r <= '0;
            dec_wren_r  <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            kv_r        <= 1'b0;
        end else begin
            state       <= state_n;
            i           <= i_n;
            j           <= j_n;
            k           <= k_n;
            si          <= si_n;
            sj          <= sj_n;
            f           <= f_n;
            enc         <= enc_n;
            s_addr_r    <= s_addr_n;
            s_wdata_r   <= s_wdata_n;
            s_wren_r    <= s_wren_n;
            rom_addr_r  <= rom_addr_n;
            dec_addr_r  <= dec_addr_n;
            dec_wdata_r <= dec_wdata_n;
            dec_wren_r  <= dec_wren_n;
            busy_r      <= busy_n;
            done_r      <= done_n;
            kv_r        <= kv_n;
        end
    end

    // Outputs named for a state are loaded on the edge entering that state
    // so they are visible (registered) for exactly that state's clock.
    always_comb begin
        state_n     = state;
        i_n         = i;
        j_n         = j;
        k_n         = k;
        si_n        = si;
        sj_n        = sj;
        f_n         = f;
        enc_n       = enc;
        s_addr_n    = s_addr_r;
        s_wdata_n   = s_wdata_r;
        s_wren_n    = s_wren_r;
        rom_addr_n  = rom_addr_r;
        dec_addr_n  = dec_addr_r;
        dec_wdata_n = dec_wdata_r;
        dec_wren_n  = dec_wren_r;
        busy_n      = busy_r;
        done_n      = done_r;
        kv_n        = kv_r;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    i_n     = '0;
                    j_n     = '0;
                    k_n     = '0;
                    kv_n    = 1'b1;
                    busy_n  = 1'b1;
                    done_n  = 1'b0;
                    state_n = INC_I;
                end
            end
            INC_I: begin
                i_n      = i + 8'd1;
                s_addr_n = i + 8'd1;
                state_n  = WAIT_SI;
            end
            WAIT_SI: state_n = READ_SI;
            READ_SI: begin
                si_n    = bus.s_q;
                j_n     = j + bus.s_q;
                state_n = ADDR_SJ;
            end
            ADDR_SJ: begin
                s_addr_n = j;
                state_n  = WAIT_SJ;
            end
            WAIT_SJ: state_n = READ_SJ;
            READ_SJ: begin
                sj_n      = bus.s_q;
                s_addr_n  = j;
                s_wdata_n = si;
                s_wren_n  = 1'b1;
                state_n   = WRITE_J;
            end
            WRITE_J: begin
                s_addr_n  = i;
                s_wdata_n = sj;
                s_wren_n  = 1'b1;
                state_n   = WRITE_I;
            end
            WRITE_I: begin
                s_wren_n = 1'b0;
                state_n  = ADDR_F;
            end
            ADDR_F: begin
                s_addr_n   = si + sj;
                rom_addr_n = k;
                state_n    = WAIT_F;
            end
            WAIT_F: state_n = READ_F;
            READ_F: begin
                // Plaintext is formed straight from the read data so that
                // dec_wdata is already registered during WRITE_DEC.
                f_n         = bus.s_q;
                enc_n       = bus.rom_q;
                dec_addr_n  = k;
                dec_wdata_n = bus.s_q ^ bus.rom_q;
                dec_wren_n  = 1'b1;
                state_n     = WRITE_DEC;
            end
            WRITE_DEC: begin
                dec_wren_n = 1'b0;
                if (!is_text(f ^ enc)) kv_n = 1'b0;
                state_n = NEXT;
            end
            NEXT: begin
                if ((EARLY_ABORT && !kv_r) || k == K_LAST) begin
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                    state_n = DONE;
                end else begin
                    k_n     = k + MSG_AW'(1);
                    state_n = INC_I;
                end
            end
            DONE: begin
                if (!bus.start) begin
                    done_n  = 1'b0;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.s_addr    = s_addr_r;
    assign bus.s_wdata   = s_wdata_r;
    assign bus.s_wren    = s_wren_r;
    assign bus.rom_addr  = rom_addr_r;
    assign bus.dec_addr  = dec_addr_r;
    assign bus.dec_wdata = dec_wdata_r;
    assign bus.dec_wren  = dec_wren_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.key_valid = kv_r;
endmodule

// File: tb/tb_rc4_decrypt_fsm.sv
// Scoreboard bench for rc4_decrypt_fsm: two instances run in lockstep,
// dut0 (MSG_LEN=32, early abort) and dut1 (MSG_LEN=9, full length).
module tb_rc4_decrypt_fsm;
    localparam int AW = 5;

    typedef struct packed {
        logic        kv;
        logic [15:0] cyc;
        logic [15:0] sw;
        logic [7:0]  dw;
    } ev_t;

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic load_s;
    always #5 clk = ~clk;

    rc4_decrypt_fsm_if #(.MSG_AW(AW)) bus0 ();
    rc4_decrypt_fsm_if #(.MSG_AW(AW)) bus1 ();

    rc4_decrypt_fsm #(.MSG_LEN(32), .MSG_AW(AW), .EARLY_ABORT(1'b1)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0.master));
    rc4_decrypt_fsm #(.MSG_LEN(9), .MSG_AW(AW), .EARLY_ABORT(1'b0)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1.master));

    logic [7:0] smem0[256], smem1[256], s_init[256];
    logic [7:0] ms[2][256];
    logic [7:0] rom[32], ks[32], pt[32], key[8];
    int         klen;
    logic [7:0] s_ar0, s_ar1;
    logic [AW-1:0] r_ar0, r_ar1;

    // Memories: registered address, combinational read of the stored address.
    always @(posedge clk) begin
        s_ar0 <= bus0.s_addr;
        s_ar1 <= bus1.s_addr;
        r_ar0 <= bus0.rom_addr;
        r_ar1 <= bus1.rom_addr;
        if (load_s) begin
            for (int x = 0; x < 256; x++) begin
                smem0[x] <= s_init[x];
                smem1[x] <= s_init[x];
            end
        end else begin
            if (bus0.s_wren) smem0[bus0.s_addr] <= bus0.s_wdata;
            if (bus1.s_wren) smem1[bus1.s_addr] <= bus1.s_wdata;
        end
    end

    assign bus0.s_q   = smem0[s_ar0];
    assign bus1.s_q   = smem1[s_ar1];
    assign bus0.rom_q = rom[r_ar0];
    assign bus1.rom_q = rom[r_ar1];
    assign bus0.start = start;
    assign bus1.start = start;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard queues ----------------
    logic [12:0] wq0[$], wq1[$];
    ev_t         ev0[$], ev1[$];

    task automatic push_w(input int d, input logic [12:0] v);
        if (d == 0) wq0.push_back(v); else wq1.push_back(v);
    endtask
    task automatic push_e(input int d, input ev_t v);
        if (d == 0) ev0.push_back(v); else ev1.push_back(v);
    endtask
    task automatic pop_w(input int d, output logic [12:0] v, output bit ok);
        v = '0;
        if (d == 0) begin ok = wq0.size() > 0; if (ok) v = wq0.pop_front(); end
        else        begin ok = wq1.size() > 0; if (ok) v = wq1.pop_front(); end
    endtask
    task automatic pop_e(input int d, output ev_t v, output bit ok);
        v = '0;
        if (d == 0) begin ok = ev0.size() > 0; if (ok) v = ev0.pop_front(); end
        else        begin ok = ev1.size() > 0; if (ok) v = ev1.pop_front(); end
    endtask

    // ---------------- reference model ----------------
    function automatic bit txt(input logic [7:0] b);
        return b == 8'h20 || (b >= 8'h61 && b <= 8'h7A);
    endfunction

    task automatic ksa();
        int jj;
        logic [7:0] t;
        for (int x = 0; x < 256; x++) s_init[x] = 8'(x);
        jj = 0;
        for (int x = 0; x < 256; x++) begin
            jj = (jj + s_init[x] + key[x % klen]) % 256;
            t = s_init[x]; s_init[x] = s_init[jj]; s_init[jj] = t;
        end
    endtask

    task automatic keystream();
        logic [7:0] s[256];
        logic [7:0] t;
        int a, b;
        for (int x = 0; x < 256; x++) s[x] = s_init[x];
        a = 0; b = 0;
        for (int n = 0; n < 32; n++) begin
            a = (a + 1) % 256;
            b = (b + s[a]) % 256;
            t = s[a]; s[a] = s[b]; s[b] = t;
            ks[n] = s[(s[a] + s[b]) % 256];
        end
    endtask

    // PRGA on the model copy of S; queues every expected write and the done event.
    task automatic model_run(input int d, input int len, input bit early);
        int a, b, n;
        bit kv;
        logic [7:0] t, p;
        ev_t e;
        a = 0; b = 0; n = 0; kv = 1'b1;
        for (int m = 0; m < len; m++) begin
            a = (a + 1) % 256;
            b = (b + ms[d][a]) % 256;
            t = ms[d][a]; ms[d][a] = ms[d][b]; ms[d][b] = t;
            p = ms[d][(ms[d][a] + ms[d][b]) % 256] ^ rom[m];
            push_w(d, {5'(m), p});
            n++;
            if (!txt(p)) kv = 1'b0;
            if (early && !kv) break;
        end
        e.kv = kv; e.cyc = 16'(13 * n); e.sw = 16'(2 * n); e.dw = 8'(n);
        push_e(d, e);
    endtask

    // ---------------- monitor ----------------
    int   cyc[2], swc[2], dwc[2];
    logic bsy_p[2], dn_p[2];

    task automatic mon(input int d, input logic dw, input logic [AW-1:0] da,
                       input logic [7:0] dd, input logic sw, input logic bsy,
                       input logic dn, input logic kv);
        logic [12:0] w;
        ev_t e;
        bit ok;
        if (!reset) begin
            check($sformatf("quiet_in_reset%0d", d), {30'd0, sw, dw}, 32'd0);
            bsy_p[d] = 1'b0;
            dn_p[d]  = 1'b0;
        end else begin
            if (bsy && !bsy_p[d]) begin cyc[d] = 0; swc[d] = 0; dwc[d] = 0; end
            if (bsy) cyc[d]++;
            if (sw || dw) check($sformatf("wren_exclusive%0d", d), {31'd0, sw & dw}, 32'd0);
            if (sw) swc[d]++;
            if (dw) begin
                dwc[d]++;
                pop_w(d, w, ok);
                if (!ok) check($sformatf("unexpected_dec_write%0d", d), 32'd1, 32'd0);
                else     check($sformatf("dec_write%0d", d), {19'd0, da, dd}, {19'd0, w});
            end
            if (dn && !dn_p[d]) begin
                pop_e(d, e, ok);
                if (!ok) check($sformatf("unexpected_done%0d", d), 32'd1, 32'd0);
                else begin
                    check($sformatf("key_valid%0d", d), {31'd0, kv}, {31'd0, e.kv});
                    check($sformatf("latency%0d", d), 32'(cyc[d]), {16'd0, e.cyc});
                    check($sformatf("s_wren_pulses%0d", d), 32'(swc[d]), {16'd0, e.sw});
                    check($sformatf("dec_wren_pulses%0d", d), 32'(dwc[d]), {24'd0, e.dw});
                end
            end
            bsy_p[d] = bsy;
            dn_p[d]  = dn;
        end
    endtask

    always @(negedge clk) begin
        mon(0, bus0.dec_wren, bus0.dec_addr, bus0.dec_wdata, bus0.s_wren,
            bus0.busy, bus0.done, bus0.key_valid);
        mon(1, bus1.dec_wren, bus1.dec_addr, bus1.dec_wdata, bus1.s_wren,
            bus1.busy, bus1.done, bus1.key_valid);
    end

    // ---------------- stimulus helpers ----------------
    task automatic load();
        @(negedge clk);
        load_s = 1'b1;
        @(negedge clk);
        load_s = 1'b0;
        for (int x = 0; x < 256; x++) begin
            ms[0][x] = s_init[x];
            ms[1][x] = s_init[x];
        end
    endtask

    task automatic wait_done();
        bit got;
        got = 1'b0;
        for (int c = 0; c < 2000 && !got; c++) begin
            @(negedge clk);
            got = bus0.done && bus1.done;
        end
        check("run_completes", {31'd0, got}, 32'd1);
    endtask

    task automatic check_s();
        int m0, m1;
        m0 = 0; m1 = 0;
        for (int x = 0; x < 256; x++) begin
            if (smem0[x] !== ms[0][x]) m0++;
            if (smem1[x] !== ms[1][x]) m1++;
        end
        check("s_final0", 32'(m0), 32'd0);
        check("s_final1", 32'(m1), 32'd0);
    endtask

    task automatic run_both(input bit hold);
        @(negedge clk);
        model_run(0, 32, 1'b1);
        model_run(1, 9, 1'b0);
        start = 1'b1;
        wait_done();
        if (!hold) begin
            start = 1'b0;
            @(negedge clk);
        end
        check_s();
    endtask

    task automatic set_key_key();
        key[0] = 8'h4B; key[1] = 8'h65; key[2] = 8'h79; klen = 3;
        ksa();
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [7:0] ct[9];
        int pos;
        reset = 1'b0; start = 1'b0; load_s = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy0", {31'd0, bus0.busy}, 32'd0);
        check("rst_done0", {31'd0, bus0.done}, 32'd0);
        check("rst_kv0",   {31'd0, bus0.key_valid}, 32'd0);
        check("rst_addr0", {19'd0, bus0.s_addr, bus0.rom_addr}, 32'd0);
        check("rst_busy1", {31'd0, bus1.busy}, 32'd0);
        check("rst_done1", {31'd0, bus1.done}, 32'd0);
        reset = 1'b1;

        // Identity S: first byte 0x63 ^ 0x02 = 'a'.
        for (int x = 0; x < 256; x++) s_init[x] = 8'(x);
        for (int x = 0; x < 32; x++) rom[x] = 8'($urandom);
        rom[0] = 8'h63;
        load();
        run_both(1'b0);

        // Key "Key", ciphertext of "Plaintext".
        ct = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
        set_key_key();
        for (int x = 0; x < 32; x++) rom[x] = (x < 9) ? ct[x] : 8'($urandom);
        load();
        run_both(1'b0);

        // Same key, all-zero ROM: raw keystream.
        for (int x = 0; x < 32; x++) rom[x] = 8'h00;
        load();
        run_both(1'b0);

        // Random keys with lowercase/space plaintext, sometimes one bad byte.
        for (int t = 0; t < 8; t++) begin
            klen = $urandom_range(1, 8);
            for (int x = 0; x < 8; x++) key[x] = 8'($urandom);
            ksa();
            keystream();
            for (int x = 0; x < 32; x++) begin
                pos = $urandom_range(0, 26);
                pt[x] = (pos == 26) ? 8'h20 : 8'h61 + 8'(pos);
            end
            if ($urandom_range(0, 1) == 1) begin
                pos = $urandom_range(0, 31);
                pt[pos] = 8'($urandom_range(0, 31));
            end
            for (int x = 0; x < 32; x++) rom[x] = pt[x] ^ ks[x];
            load();
            run_both(1'b0);
        end

        // Reset during WAIT_SJ of the second byte, then a clean rerun.
        set_key_key();
        keystream();
        for (int x = 0; x < 32; x++) rom[x] = ks[x] ^ 8'h71;
        load();
        @(negedge clk);
        model_run(0, 32, 1'b1);
        model_run(1, 9, 1'b0);
        start = 1'b1;
        @(posedge clk);
        repeat (17) @(posedge clk);
        #2;
        reset = 1'b0;
        start = 1'b0;
        wq0.delete(); wq1.delete(); ev0.delete(); ev1.delete();
        #1;
        check("abort_busy0", {31'd0, bus0.busy}, 32'd0);
        check("abort_busy1", {31'd0, bus1.busy}, 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        load();
        run_both(1'b0);

        // start held through DONE: no rerun until it drops.
        load();
        run_both(1'b1);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("hold_done", {30'd0, bus0.done, bus1.done}, 32'd3);
            check("hold_busy", {30'd0, bus0.busy, bus1.busy}, 32'd0);
        end
        start = 1'b0;
        @(posedge clk);
        #1;
        check("done_clear", {30'd0, bus0.done, bus1.done}, 32'd0);
        load();
        run_both(1'b0);
        // Rerun on the already-permuted S continues from the model's copy.
        run_both(1'b0);

        repeat (2) @(negedge clk);
        check("scoreboard_drained", 32'(wq0.size() + wq1.size() + ev0.size() + ev1.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/rc4_decrypt_fsm.md
Name: rc4_decrypt_fsm

Overview:
- Final RC4 stage, directly downstream of the key-schedule (shuffle) stage; starts when that stage asserts its completion strobe.
- Runs the pseudo-random generation algorithm over the shuffled 256-byte S memory.
- XORs each keystream byte with the matching encrypted-message ROM byte and writes the plaintext to the decrypted-message RAM.
- Flags whether the result is all lowercase/space, which the key-search controller uses to accept or reject the current secret key.

Parameters:
- MSG_LEN, 32, number of message bytes processed (1..2**MSG_AW).
- MSG_AW, 5, address width of the message ROM and decrypted RAM.
- EARLY_ABORT, 1, 1 = stop at the first invalid plaintext character; 0 = always process MSG_LEN bytes.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- start  input  1  level; high = shuffle complete, begin decryption
- s_q  input  8  S RAM read data
- s_addr  output  8  S RAM address
- s_wdata  output  8  S RAM write data
- s_wren  output  1  S RAM write enable
- rom_q  input  8  encrypted ROM read data
- rom_addr  output  MSG_AW  encrypted ROM address
- dec_addr  output  MSG_AW  decrypted RAM address
- dec_wdata  output  8  decrypted RAM write data
- dec_wren  output  1  decrypted RAM write enable
- busy  output  1  high from leaving IDLE until entering DONE
- done  output  1  high while in DONE
- key_valid  output  1  valid when done=1; 1 = every written byte is 0x61..0x7A or 0x20

Behaviour:
- Reset (asynchronous, active-low): state IDLE; i, j, k, si, sj, f, enc cleared; all outputs 0.
- Memory timing: S RAM and ROM have a registered address and 2-cycle read latency. Data is sampled 2 clocks after the address register updates, so every read has one WAIT state. All outputs are registered.
- IDLE: on start=1, clear i, j and k to 0, set key_valid=1, go to INC_I.
- INC_I: i <= i+1 (8-bit wrap); s_addr <= i+1.
- WAIT_SI: no action.
- READ_SI: si <= s_q; j <= j + s_q (mod 256).
- ADDR_SJ: s_addr <= j.
- WAIT_SJ: no action.
- READ_SJ: sj <= s_q.
- WRITE_J: s_addr = j, s_wdata = si, s_wren = 1.
- WRITE_I: s_addr = i, s_wdata = sj, s_wren = 1.
- ADDR_F: s_wren = 0; s_addr <= si + sj (mod 256); rom_addr <= k.
- WAIT_F: no action.
- READ_F: f <= s_q; enc <= rom_q.
- WRITE_DEC: dec_addr = k, dec_wdata = f ^ enc, dec_wren = 1. If the byte is not in 0x61..0x7A and not 0x20, key_valid <= 0.
- NEXT: dec_wren = 0.
  - If (EARLY_ABORT and key_valid=0) or k == MSG_LEN-1, go to DONE.
  - Otherwise k <= k+1 and go to INC_I.
- DONE: done = 1, busy = 0, all write enables 0. When start=0, go to IDLE, clearing done; key_valid holds until the next start.
- Write strobes: each write enable is high for exactly one clock per write. s_wren and dec_wren are never high together.
- Latency: 13 clocks per byte. MSG_LEN=32 gives 416 clocks from the first INC_I to DONE entry.
- i == j case: both swap writes go to the same address with the same value, S is unchanged, and no special case is needed.
- start high outside IDLE is ignored. start held high in DONE keeps the FSM in DONE (no re-run) until start drops.
- Reset mid-operation aborts immediately. Partially written RAM contents are not restored.
- Width rules: i, j, si, sj and the S index arithmetic are 8-bit, truncated mod 256. k is MSG_AW bits wide.

Test Plan:
- S preloaded with identity (s[x]=x), rom[0]=0x63, MSG_LEN=1 -> i=1, j=1, keystream f=0x02, dec[0]=0x61, key_valid=1, done at clock 13.
- S preloaded with the KSA result for key 0x4B6579 ("Key"), MSG_LEN=9, EARLY_ABORT=0, rom = BB F3 16 E8 D9 40 AF 0A D3 -> dec = "Plaintext", key_valid=0 (because of 'P'), exactly 9 dec_wren pulses and 18 s_wren pulses.
- Same setup with EARLY_ABORT=1 -> one dec_wren pulse (dec[0]=0x50), DONE entered after 13 clocks, key_valid=0.
- Same key, all-zero ROM, MSG_LEN=4 -> dec = EB 9F 77 81.
- Reset asserted in WAIT_SJ of byte 2, then released and start raised -> FSM restarts with i=j=k=0 and reproduces the full correct output. No write occurs while reset is low.
- Hold start high through DONE for 20 clocks, then drop it, then raise it again -> no second run until start returns low; done clears 1 clock after start=0; second run gives identical results only if S is reloaded.
